// File: rtl/ext_shift_pipe.sv
// rtl/ext_shift_pipe.sv - sign/zero-extend, left-shift and truncate an immediate field through a DEPTH-stage valid/ready pipe
// Optional statistics counters are built when EXT_STATS_EN is defined.
module ext_shift_pipe #(
  parameter int IN_WIDTH  = 11,
  parameter int OUT_WIDTH = 16,
  parameter int SHAMT_W   = 2,
  parameter int DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_WIDTH-1:0]              in_data,
  input  logic [$clog2(IN_WIDTH+1)-1:0]    in_len,
  input  logic                             in_signed,
  input  logic [SHAMT_W-1:0]               in_shamt,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic                             out_ovf
`ifdef EXT_STATS_EN
  ,
  output logic [15:0]                      stat_xfers,
  output logic [15:0]                      stat_ovf
`endif
);

  localparam int LEN_W = $clog2(IN_WIDTH + 1);
  localparam int TOP_W = (1 << SHAMT_W) - 1;
  localparam int EXT_W = OUT_WIDTH + TOP_W;
  localparam int PAD_W = (EXT_W > IN_WIDTH) ? EXT_W : IN_WIDTH;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IN_WIDTH);

  logic [LEN_W-1:0]     len_c;
  logic [PAD_W-1:0]     din_pad;
  logic                 sign_c;
  logic [EXT_W-1:0]     ext_c;
  logic [EXT_W-1:0]     shifted_c;
  logic [TOP_W-1:0]     top_c;
  logic                 ovf_c;

  assign din_pad = PAD_W'(in_data);

  // ext_c is wide enough that the largest shift never drops a bit before the overflow check
  always_comb begin
    len_c  = (in_len > MAX_LEN) ? MAX_LEN : in_len;
    sign_c = 1'b0;
    ext_c  = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (i == int'(len_c) - 1) sign_c = din_pad[i];
    end
    sign_c = sign_c & in_signed;
    for (int i = 0; i < EXT_W; i++) begin
      if (i < int'(len_c)) ext_c[i] = din_pad[i];
      else                 ext_c[i] = sign_c;
    end
  end

  assign shifted_c = ext_c << in_shamt;
  assign top_c     = shifted_c[EXT_W-1:OUT_WIDTH];
  assign ovf_c     = in_signed ? (top_c != {TOP_W{shifted_c[OUT_WIDTH-1]}}) : (|top_c);

  logic [DEPTH-1:0]     v;
  logic [DEPTH-1:0]     o;
  logic [OUT_WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0]     load;
  logic [DEPTH-1:0]     vin;
  logic [DEPTH-1:0]     oin;
  logic [OUT_WIDTH-1:0] din [DEPTH];

  // A stage may load when any stage at or after it has a hole, or the sink drains
  always_comb begin : advance
    logic room;
    room = out_ready;
    load = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      room    = room | ~v[k];
      load[k] = room;
    end
  end

  always_comb begin
    vin    = '0;
    oin    = '0;
    vin[0] = in_valid;
    oin[0] = ovf_c;
    din[0] = shifted_c[OUT_WIDTH-1:0];
    for (int k = 1; k < DEPTH; k++) begin
      vin[k] = v[k-1];
      oin[k] = o[k-1];
      din[k] = d[k-1];
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      o <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          v[k] <= vin[k];
          // payload only moves with a valid beat, so idle inputs never reach the registers
          if (vin[k]) begin
            d[k] <= din[k];
            o[k] <= oin[k];
          end
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_ovf   = o[DEPTH-1];

`ifdef EXT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_xfers <= '0;
      stat_ovf   <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_xfers != 16'hFFFF) stat_xfers <= stat_xfers + 16'd1;
      if (out_ovf && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_shift_pipe.sv
// tb/tb_ext_shift_pipe.sv - scoreboard bench for ext_shift_pipe (default width and a 12-bit result instance)
module tb_ext_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [10:0] in_data;
  logic [3:0]  in_len;
  logic        in_signed;
  logic [1:0]  in_shamt;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [11:0] out_data_b;
`ifdef EXT_STATS_EN
  logic [15:0] stat_xfers_a, stat_ovf_a, stat_xfers_b, stat_ovf_b;
`endif

  always #5 clk = ~clk;

  ext_shift_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_len(in_len), .in_signed(in_signed), .in_shamt(in_shamt),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a)
`ifdef EXT_STATS_EN
    , .stat_xfers(stat_xfers_a), .stat_ovf(stat_ovf_a)
`endif
  );

  ext_shift_pipe #(.OUT_WIDTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_len(in_len), .in_signed(in_signed), .in_shamt(in_shamt),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_ovf(out_ovf_b)
`ifdef EXT_STATS_EN
    , .stat_xfers(stat_xfers_b), .stat_ovf(stat_ovf_b)
`endif
  );

  typedef struct packed {
    logic [10:0] data;
    logic [3:0]  len;
    logic        sg;
    logic [1:0]  sh;
    logic [15:0] ea;
    logic        oa;
    logic [15:0] eb;
    logic        ob;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_x = 0;
  int   exp_ov = 0;
  vec_t dir [9];
  vec_t idle;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: treat the field as an integer, shift by multiplication, test representability
  function automatic void model(input logic [10:0] data, input logic [3:0] len, input logic sg,
                                input logic [1:0] sh, input int ow,
                                output logic [15:0] d, output logic o);
    int     l;
    longint f, val, s;
    l   = (len > 4'd11) ? 11 : int'(len);
    f   = longint'(data) & ((longint'(1) << l) - 1);
    val = f;
    if (sg && l > 0 && f >= (longint'(1) << (l - 1))) val = f - (longint'(1) << l);
    s   = val * (longint'(1) << sh);
    d   = 16'(s & ((longint'(1) << ow) - 1));
    if (sg) o = (s >= (longint'(1) << (ow - 1))) || (s < -(longint'(1) << (ow - 1)));
    else    o = (s >= (longint'(1) << ow));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk(input int w, input logic v, input logic [15:0] d, input logic o);
    exp_t e;
    if (!v) return;
    if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_out dut%0d actual=%h required=none", w, d);
      return;
    end
    e = (w == 0) ? qa[0] : qb[0];
    if (out_ready) begin
      if (w == 0) void'(qa.pop_front());
      else        void'(qb.pop_front());
    end
    check($sformatf("out_data_dut%0d", w), 32'(d), 32'(e.d));
    check($sformatf("out_ovf_dut%0d", w), 32'(o), 32'(e.o));
    if (out_ready && e.lat) check($sformatf("latency_dut%0d", w), cyc - e.acc, 2);
    if (w == 0 && out_ready) begin
      exp_x++;
      if (e.o) exp_ov++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk(0, out_valid_a, out_data_a, out_ovf_a);
        chk(1, out_valid_b, {4'h0, out_data_b}, out_ovf_b);
      end
    end
  end

  task automatic step(input bit iv, input vec_t t, input bit ordy, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_data   = t.data;
    in_len    = t.len;
    in_signed = t.sg;
    in_shamt  = t.sh;
    out_ready = ordy;
    #1;
    acc = iv && in_ready_a;
    if (acc) begin
      e.acc = cyc;
      e.lat = lat;
      e.d = t.ea; e.o = t.oa; qa.push_back(e);
      e.d = t.eb; e.o = t.ob; qb.push_back(e);
    end
  endtask

  task automatic send(input vec_t t, input bit ordy, input bit lat);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, t, ordy, lat, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  initial begin
    bit   acc;
    int   idx;
    int   n;
    vec_t t;

    dir[0] = '{11'h0FF, 4'd9,  1'b1, 2'd1, 16'h01FE, 1'b0, 16'h01FE, 1'b0};
    dir[1] = '{11'h1F0, 4'd9,  1'b1, 2'd1, 16'hFFE0, 1'b0, 16'h0FE0, 1'b0};
    dir[2] = '{11'h1F0, 4'd9,  1'b0, 2'd1, 16'h03E0, 1'b0, 16'h03E0, 1'b0};
    dir[3] = '{11'h7AB, 4'd8,  1'b0, 2'd1, 16'h0156, 1'b0, 16'h0156, 1'b0};
    dir[4] = '{11'h7FF, 4'd11, 1'b0, 2'd2, 16'h1FFC, 1'b0, 16'h0FFC, 1'b1};
    dir[5] = '{11'h7FF, 4'd11, 1'b1, 2'd2, 16'hFFFC, 1'b0, 16'h0FFC, 1'b0};
    dir[6] = '{11'h5A5, 4'd0,  1'b1, 2'd3, 16'h0000, 1'b0, 16'h0000, 1'b0};
    dir[7] = '{11'h400, 4'd15, 1'b1, 2'd0, 16'hFC00, 1'b0, 16'h0C00, 1'b0};
    dir[8] = '{11'h400, 4'd11, 1'b0, 2'd3, 16'h2000, 1'b0, 16'h0000, 1'b1};
    idle = '0;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0;
    in_signed = 1'b0; in_shamt = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid_a), 0);
    check("reset_out_data", 32'(out_data_a), 0);
    check("reset_out_ovf", 32'(out_ovf_a), 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready_a), 1);

    // Directed vectors, back to back with the sink always ready
    for (int i = 0; i < 9; i++) send(dir[i], 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0, acc);

    // Backpressure: only DEPTH beats fit while the sink stalls
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, dir[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepts", idx, 2);
    check("bp_in_ready", 32'(in_ready_a), 0);
    check("bp_out_valid", 32'(out_valid_a), 1);
    n = 0;
    while (idx < 4 && n < 20) begin
      step(1'b1, dir[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
      n++;
    end
    check("bp_release_accepts", idx, 4);

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      t.data = 11'($urandom);
      t.len  = 4'($urandom_range(0, 15));
      t.sg   = 1'($urandom);
      t.sh   = 2'($urandom);
      model(t.data, t.len, t.sg, t.sh, 16, t.ea, t.oa);
      model(t.data, t.len, t.sg, t.sh, 12, t.eb, t.ob);
      step($urandom_range(0, 3) != 0, t, $urandom_range(0, 3) != 0, 1'b0, acc);
    end

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      step(1'b0, idle, 1'b1, 1'b0, acc);
      n++;
    end
    check("drain_empty", qa.size() + qb.size(), 0);
`ifdef EXT_STATS_EN
    check("stat_xfers", 32'(stat_xfers_a), exp_x);
    check("stat_ovf", 32'(stat_ovf_a), exp_ov);
`endif

    // Reset with two beats in flight
    send(dir[1], 1'b0, 1'b0);
    send(dir[3], 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, acc);
    check("pre_reset_out_valid", 32'(out_valid_a), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid_a), 0);
    check("async_reset_out_data", 32'(out_data_a), 0);
    check("async_reset_out_ovf", 32'(out_ovf_a), 0);
    qa.delete();
    qb.delete();
`ifdef EXT_STATS_EN
    check("reset_stat_xfers", 32'(stat_xfers_a), 0);
    check("reset_stat_ovf", 32'(stat_ovf_a), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_reset_in_ready", 32'(in_ready_a), 1);
    for (int i = 0; i < 5; i++) step(1'b0, idle, 1'b1, 1'b0, acc);
    send(dir[7], 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0, acc);
    check("final_empty", qa.size() + qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
